cache_stats_monitor: RTL and testbench

//  Parametrised hit/miss statistics engine for an N-level cache hierarchy.
//  - Sits beside the cache levels and main memory and samples per-level hit flags each access.
//  - Classifies each access: hit at the first (lowest-index) level, or miss at all levels.
//  - Keeps per-level hit counters, a miss counter and an access counter.
//  - Software reads the counters through a coherent snapshot and a 1-cycle-latency read port.

---
 rtl/cache_stats_monitor_if.sv | 31 +++
 rtl/cache_stats_monitor.sv | 112 +++++++++++
 tb/tb_cache_stats_monitor.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_stats_monitor_if.sv
// Bus bundle for cache_stats_monitor: access sampling, control strobes,
// the snapshot read port and the sticky saturation flag.
// master = the agent driving accesses/commands, slave = the monitor.
interface cache_stats_monitor_if #(
    parameter int LEVELS = 3,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = $clog2(LEVELS + 2);

    // Read handshake: rd_req in cycle t is always accepted (no ready
    // signal, no stall); rd_valid/rd_data answer it in cycle t+1.
    logic              access_valid;
    logic [LEVELS-1:0] hit_vec;
    logic              clear;
    logic              snap;
    logic              rd_req;
    logic [SEL_W-1:0]  rd_sel;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              any_sat;

    modport master (
        output access_valid, hit_vec, clear, snap, rd_req, rd_sel,
        input  rd_valid, rd_data, any_sat
    );

    modport slave (
        input  access_valid, hit_vec, clear, snap, rd_req, rd_sel,
        output rd_valid, rd_data, any_sat
    );
endinterface

// File: rtl/cache_stats_monitor.sv
// cache_stats_monitor: per-level hit / miss / access counters for an
// N-level cache hierarchy, with a shadow bank for coherent software reads.
// Counter slot layout (live and shadow): 0 = accesses, 1..LEVELS = hits
// at level slot-1, LEVELS+1 = misses.
// Optional feature macro STATS_WRAP_EN: counters wrap modulo 2^CNT_W
// instead of saturating; any_sat then flags the wrap.
module cache_stats_monitor #(
    parameter int LEVELS = 3,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_stats_monitor_if.slave bus
);
    localparam int SEL_W = $clog2(LEVELS + 2);
    localparam int NCNT  = LEVELS + 2;

    logic [CNT_W-1:0] live_q   [NCNT];
    logic [CNT_W-1:0] live_d   [NCNT];
    logic [CNT_W-1:0] shadow_q [NCNT];
    logic [NCNT-1:0]  inc;
    logic [NCNT-1:0]  ovf;
    logic             found;
    logic [CNT_W-1:0] rd_mux;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             any_sat_q;

    // Classify the access: one access bump plus exactly one of
    // first-level-hit or miss.
    always_comb begin
        inc   = '0;
        found = 1'b0;
        if (bus.access_valid) begin
            inc[0] = 1'b1;
            for (int k = 0; k < LEVELS; k++) begin
                if (!found && bus.hit_vec[k]) begin
                    inc[k+1] = 1'b1;
                    found    = 1'b1;
                end
            end
            inc[NCNT-1] = !found;
        end
    end

    // Next live values; ovf marks an increment attempted at all-ones.
    always_comb begin
        ovf = '0;
        for (int i = 0; i < NCNT; i++) begin
            live_d[i] = live_q[i];
            if (inc[i]) begin
                if (&live_q[i]) begin
                    ovf[i] = 1'b1;
`ifdef STATS_WRAP_EN
                    live_d[i] = '0;
`else
                    live_d[i] = live_q[i];
`endif
                end else begin
                    live_d[i] = live_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Live counters and sticky flag; clear wins over a same-cycle access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) live_q[i] <= '0;
            any_sat_q <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < NCNT; i++) live_q[i] <= '0;
            any_sat_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCNT; i++) live_q[i] <= live_d[i];
            if (|ovf) any_sat_q <= 1'b1;
        end
    end

    // Shadow bank captures the live values as they stood at the start of
    // the snap cycle, so a same-cycle access or clear is not included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) shadow_q[i] <= '0;
        end else if (bus.snap) begin
            for (int i = 0; i < NCNT; i++) shadow_q[i] <= live_q[i];
        end
    end

    // Select a shadow slot; out-of-range selects read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (bus.rd_sel == SEL_W'(i)) rd_mux = shadow_q[i];
        end
    end

    // One-cycle read pipeline; rd_data holds when no request is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_req;
            if (bus.rd_req) rd_data_q <= rd_mux;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.any_sat  = any_sat_q;
endmodule

// File: tb/tb_cache_stats_monitor.sv
// Directed bench for cache_stats_monitor (LEVELS=3, CNT_W=8) with a
// reference counter model and an expected-read queue.
module tb_cache_stats_monitor;
    localparam int LEVELS = 3;
    localparam int CNT_W  = 8;
    localparam int NCNT   = LEVELS + 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cache_stats_monitor_if #(.LEVELS(LEVELS), .CNT_W(CNT_W)) bus ();

    cache_stats_monitor #(.LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [CNT_W-1:0] m_live   [NCNT];
    logic [CNT_W-1:0] m_shadow [NCNT];
    logic             m_sat;
    logic [CNT_W-1:0] exp_q [$];
    logic [CNT_W-1:0] last_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCNT; i++) begin
            m_live[i]   = '0;
            m_shadow[i] = '0;
        end
        m_sat = 1'b0;
    endtask

    task automatic model_bump(input int idx);
        if (m_live[idx] == {CNT_W{1'b1}}) begin
            m_sat = 1'b1;
`ifdef STATS_WRAP_EN
            m_live[idx] = '0;
`endif
        end else begin
            m_live[idx] = m_live[idx] + 1'b1;
        end
    endtask

    task automatic model_access(input logic [LEVELS-1:0] hv);
        int slot;
        slot = NCNT - 1;
        for (int k = LEVELS - 1; k >= 0; k--) if (hv[k]) slot = k + 1;
        model_bump(0);
        model_bump(slot);
    endtask

    task automatic model_snap();
        for (int i = 0; i < NCNT; i++) m_shadow[i] = m_live[i];
    endtask

    function automatic logic [CNT_W-1:0] exp_of(input int sel);
        return (sel < NCNT) ? m_shadow[sel] : '0;
    endfunction

    // driver tasks
    task automatic do_access(input logic [LEVELS-1:0] hv);
        bus.access_valid = 1'b1;
        bus.hit_vec      = hv;
        model_access(hv);
        tick();
        bus.access_valid = 1'b0;
        bus.hit_vec      = '0;
    endtask

    task automatic do_snap();
        bus.snap = 1'b1;
        model_snap();
        tick();
        bus.snap = 1'b0;
    endtask

    task automatic check_rd(input string tag);
        logic [CNT_W-1:0] e;
        check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(bus.rd_data), 64'(e));
            last_rd = e;
        end
    endtask

    task automatic do_read(input int sel, input string tag);
        bus.rd_req = 1'b1;
        bus.rd_sel = 3'(sel);
        exp_q.push_back(exp_of(sel));
        tick();
        bus.rd_req = 1'b0;
        check_rd(tag);
    endtask

    // back-to-back reads of every slot, rd_req held high throughout
    task automatic read_all(input string tag);
        bus.rd_req = 1'b1;
        for (int s = 0; s < NCNT; s++) begin
            bus.rd_sel = 3'(s);
            exp_q.push_back(exp_of(s));
            tick();
            check_rd($sformatf("%s_sel%0d", tag, s));
        end
        bus.rd_req = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_rd = '0;
        rst_n = 1'b0;
        bus.access_valid = 1'b0;
        bus.hit_vec      = '0;
        bus.clear        = 1'b0;
        bus.snap         = 1'b0;
        bus.rd_req       = 1'b0;
        bus.rd_sel       = '0;
        model_reset();

        // reset state
        tick();
        tick();
        check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        check("reset_any_sat", 64'(bus.any_sat), 64'd0);
        rst_n = 1'b1;
        tick();

        // five level-0 hits
        for (int i = 0; i < 5; i++) do_access(3'b001);
        do_snap();
        do_read(0, "t1_access");
        do_read(1, "t1_hit0");
        do_read(4, "t1_miss");
        // rd_req low: valid drops, data holds
        tick();
        check("hold_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("hold_rd_data", 64'(bus.rd_data), 64'(last_rd));

        // lowest-index hit wins; all-zero is a miss; hit_vec ignored when idle
        do_access(3'b110);
        do_access(3'b000);
        bus.hit_vec = 3'b111;
        tick();
        bus.hit_vec = '0;
        do_snap();
        read_all("t2");

        // access + snap + read in the same cycle
        do_access(3'b001);
        bus.access_valid = 1'b1;
        bus.hit_vec      = 3'b100;
        bus.snap         = 1'b1;
        bus.rd_req       = 1'b1;
        bus.rd_sel       = 3'd0;
        exp_q.push_back(exp_of(0));
        model_snap();
        model_access(3'b100);
        tick();
        bus.access_valid = 1'b0;
        bus.hit_vec      = '0;
        bus.snap         = 1'b0;
        bus.rd_req       = 1'b0;
        check_rd("t3_read_during_snap");
        do_read(0, "t3_shadow_n");
        do_snap();
        do_read(0, "t3_live_n1");
        do_read(3, "t3_hit2");

        // clear + access + snap: shadow keeps pre-clear values, access dropped
        bus.clear        = 1'b1;
        bus.access_valid = 1'b1;
        bus.hit_vec      = 3'b010;
        bus.snap         = 1'b1;
        model_snap();
        for (int i = 0; i < NCNT; i++) m_live[i] = '0;
        m_sat = 1'b0;
        tick();
        bus.clear        = 1'b0;
        bus.access_valid = 1'b0;
        bus.hit_vec      = '0;
        bus.snap         = 1'b0;
        read_all("t4_old");
        do_snap();
        read_all("t4_zero");

        // random traffic, then invariant-bearing readback
        for (int i = 0; i < 20; i++) do_access(3'($urandom_range(0, 7)));
        do_snap();
        read_all("rand");

        // 256 misses with 8-bit counters
        bus.clear = 1'b1;
        for (int i = 0; i < NCNT; i++) m_live[i] = '0;
        m_sat = 1'b0;
        tick();
        bus.clear = 1'b0;
        check("clear_any_sat", 64'(bus.any_sat), 64'd0);
        for (int i = 0; i < 256; i++) do_access(3'b000);
        check("t5_any_sat", 64'(bus.any_sat), 64'd1);
        do_snap();
`ifdef STATS_WRAP_EN
        check("t5_model_miss", 64'(m_shadow[4]), 64'd0);
`else
        check("t5_model_miss", 64'(m_shadow[4]), 64'd255);
`endif
        do_read(4, "t5_miss");
        do_read(0, "t5_access");
        do_read(1, "t5_hit0");
        // any_sat is sticky until clear
        do_access(3'b001);
        check("t5_sticky", 64'(bus.any_sat), 64'(m_sat));
        bus.clear = 1'b1;
        for (int i = 0; i < NCNT; i++) m_live[i] = '0;
        m_sat = 1'b0;
        tick();
        bus.clear = 1'b0;
        check("t5_cleared_sat", 64'(bus.any_sat), 64'd0);

        // out-of-range select
        do_read(7, "t6_sel7");
        do_read(5, "t6_sel5");

        // reset while a read is in flight
        do_access(3'b100);
        do_snap();
        bus.rd_req = 1'b1;
        bus.rd_sel = 3'd0;
        tick();
        check("t6_pre_rst_valid", 64'(bus.rd_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(bus.rd_valid), 64'd0);
        check("t6_rst_data", 64'(bus.rd_data), 64'd0);
        bus.rd_req = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        read_all("t6_after_rst");

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
